// File: rtl/eq_arbiter.sv
// Two-requester arbiter feeding a shared expression checker.
// Grant is held for a whole expression, ended by '=', length or idle timeout.
module eq_arbiter #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       chk_valid,
    output logic [7:0] chk_data,
    input  logic       chk_ready,
    input  logic       chk_result,
    output logic       chk_clr,
    output logic       owner,
    output logic       done,
    output logic       done_ok,
    output logic       abort
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        DONE,
        ABORT,
        CLEAR
    } state_t;

    localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);
    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);
    localparam logic [7:0] EQ_CHAR   = 8'h3D;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic [4:0] len_cnt_q, len_cnt_d;
    logic [4:0] idle_cnt_q, idle_cnt_d;

    logic       busy;
    logic       own_valid;
    logic [7:0] own_data;
    logic       xfer;

    always_comb begin
        busy       = (state_q == BUSY);
        own_valid  = owner_q ? req1_valid : req0_valid;
        own_data   = owner_q ? req1_data : req0_data;
        chk_valid  = busy & own_valid;
        chk_data   = busy ? own_data : 8'h00;
        req0_ready = busy & ~owner_q & chk_ready;
        req1_ready = busy & owner_q & chk_ready;
        xfer       = chk_valid & chk_ready;
        done       = (state_q == DONE);
        abort      = (state_q == ABORT);
        chk_clr    = (state_q == CLEAR);
        done_ok    = done & chk_result;
        owner      = owner_q;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        len_cnt_d  = len_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    // On contention the requester that did not go last wins
                    if (req0_valid & req1_valid) owner_d = ~last_q;
                    else                         owner_d = req1_valid;
                    len_cnt_d  = 5'd0;
                    idle_cnt_d = 5'd0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    idle_cnt_d = 5'd0;
                    if (own_data == EQ_CHAR) begin
                        state_d = DONE;
                    end else begin
                        len_cnt_d = len_cnt_q + 5'd1;
                        if (len_cnt_d == MAX_LEN_C) state_d = ABORT;
                    end
                end else if (!own_valid) begin
                    idle_cnt_d = idle_cnt_q + 5'd1;
                    if (idle_cnt_d == TIMEOUT_C) state_d = ABORT;
                end
            end
            DONE:  state_d = CLEAR;
            ABORT: state_d = CLEAR;
            CLEAR: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            len_cnt_q  <= 5'd0;
            idle_cnt_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            len_cnt_q  <= len_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_eq_arbiter.sv
// Directed bench for eq_arbiter: grant, forwarding, exits and reset.
// Inputs change just after the rising edge; outputs are sampled 1 ns later.
module tb_eq_arbiter;

    localparam logic [7:0] CH_A  = 8'h61;
    localparam logic [7:0] CH_B  = 8'h62;
    localparam logic [7:0] CH_X  = 8'h78;
    localparam logic [7:0] CH_Z  = 8'h7A;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_PL = 8'h2B;
    localparam logic [7:0] CH_EQ = 8'h3D;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       chk_valid;
    logic [7:0] chk_data;
    logic       chk_ready, chk_result;
    logic       chk_clr, owner, done, done_ok, abort;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eq_arbiter #(.MAX_LEN(16), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .chk_valid  (chk_valid),
        .chk_data   (chk_data),
        .chk_ready  (chk_ready),
        .chk_result (chk_result),
        .chk_clr    (chk_clr),
        .owner      (owner),
        .done       (done),
        .done_ok    (done_ok),
        .abort      (abort)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_r0"}, 32'(req0_ready), 32'd0);
        check({tag, "_r1"}, 32'(req1_ready), 32'd0);
        check({tag, "_cv"}, 32'(chk_valid), 32'd0);
        check({tag, "_cd"}, 32'(chk_data), 32'd0);
        check({tag, "_clr"}, 32'(chk_clr), 32'd0);
        check({tag, "_dn"}, 32'(done), 32'd0);
        check({tag, "_ok"}, 32'(done_ok), 32'd0);
        check({tag, "_ab"}, 32'(abort), 32'd0);
        check({tag, "_own"}, 32'(owner), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        string s1 = "a+1=";
        string s3 = "a+a+a+a+a+a+a+a+";
        string s5 = "b*2=";
        logic [7:0] rx[4];
        int rx_n;
        int idx;
        int dn;
        int g;

        reset      = 1'b0;
        chk_ready  = 1'b1;
        chk_result = 1'b1;
        idle_inputs();
        #3;
        outs_zero("rst");
        tick();
        tick();
        reset = 1'b1;

        // "a+1=" from requester 0
        req0_valid = 1'b1;
        req0_data  = s1[0];
        settle();
        check("t1_idle_r0", 32'(req0_ready), 32'd0);
        check("t1_idle_cv", 32'(chk_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            req0_data = s1[i];
            settle();
            check("t1_cv", 32'(chk_valid), 32'd1);
            check("t1_cd", 32'(chk_data), 32'(s1[i]));
            check("t1_r0", 32'(req0_ready), 32'd1);
            tick();
        end
        req0_valid = 1'b0;
        settle();
        check("t1_done", 32'(done), 32'd1);
        check("t1_ok", 32'(done_ok), 32'd1);
        check("t1_own", 32'(owner), 32'd0);
        check("t1_ab", 32'(abort), 32'd0);
        tick();
        check("t1_clr", 32'(chk_clr), 32'd1);
        check("t1_dn0", 32'(done), 32'd0);
        tick();

        // both requesters, "x=" each, round-robin
        do_reset();
        chk_ready  = 1'b1;
        chk_result = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = CH_X;
            req1_data  = CH_X;
            settle();
            check("t2_idle_r0", 32'(req0_ready), 32'd0);
            check("t2_idle_r1", 32'(req1_ready), 32'd0);
            tick();
            check("t2_own", 32'(owner), 32'(g));
            check("t2_cd_x", 32'(chk_data), 32'(CH_X));
            check("t2_r0", 32'(req0_ready), 32'(g == 0));
            check("t2_r1", 32'(req1_ready), 32'(g == 1));
            tick();
            if (g == 0) req0_data = CH_EQ;
            else        req1_data = CH_EQ;
            settle();
            check("t2_cd_eq", 32'(chk_data), 32'(CH_EQ));
            check("t2_r0b", 32'(req0_ready), 32'(g == 0));
            check("t2_r1b", 32'(req1_ready), 32'(g == 1));
            tick();
            check("t2_done", 32'(done), 32'd1);
            check("t2_own2", 32'(owner), 32'(g));
            tick();
            tick();
        end

        // 16 characters without '=' from requester 1
        idle_inputs();
        req1_valid = 1'b1;
        req1_data  = s3[0];
        tick();
        for (int i = 0; i < 16; i++) begin
            req1_data = s3[i];
            settle();
            check("t3_cd", 32'(chk_data), 32'(s3[i]));
            check("t3_r1", 32'(req1_ready), 32'd1);
            check("t3_ab0", 32'(abort), 32'd0);
            tick();
        end
        req1_valid = 1'b0;
        settle();
        check("t3_ab", 32'(abort), 32'd1);
        check("t3_dn", 32'(done), 32'd0);
        check("t3_ok", 32'(done_ok), 32'd0);
        check("t3_own", 32'(owner), 32'd1);
        tick();
        check("t3_clr", 32'(chk_clr), 32'd1);
        check("t3_ab1", 32'(abort), 32'd0);
        tick();

        // idle timeout with a backpressure stall in the middle
        req0_valid = 1'b1;
        req0_data  = CH_A;
        tick();
        check("t4_own", 32'(owner), 32'd0);
        check("t4_cd_a", 32'(chk_data), 32'(CH_A));
        tick();
        req0_data = CH_PL;
        settle();
        check("t4_cd_p", 32'(chk_data), 32'(CH_PL));
        tick();
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b0;
            settle();
            check("t4_ab_i1", 32'(abort), 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1;
            req0_data  = CH_1;
            chk_ready  = 1'b0;
            settle();
            check("t4_st_cv", 32'(chk_valid), 32'd1);
            check("t4_st_r0", 32'(req0_ready), 32'd0);
            check("t4_ab_st", 32'(abort), 32'd0);
            tick();
        end
        chk_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = 1'b0;
            settle();
            check("t4_ab_i2", 32'(abort), 32'd0);
            tick();
        end
        check("t4_ab", 32'(abort), 32'd1);
        check("t4_dn", 32'(done), 32'd0);
        tick();
        tick();

        // chk_ready toggling during "b*2="
        chk_result = 1'b0;
        chk_ready  = 1'b1;
        req0_valid = 1'b1;
        req0_data  = CH_B;
        tick();
        idx  = 0;
        rx_n = 0;
        for (int c = 0; c < 7; c++) begin
            chk_ready = (c % 2 == 0);
            req0_data = s5[idx];
            settle();
            check("t5_cd", 32'(chk_data), 32'(s5[idx]));
            check("t5_r0", 32'(req0_ready), 32'(c % 2 == 0));
            check("t5_dn0", 32'(done), 32'd0);
            if (chk_valid && chk_ready && rx_n < 4) begin
                rx[rx_n] = chk_data;
                rx_n++;
            end
            tick();
            if (c % 2 == 0) idx++;
        end
        req0_valid = 1'b0;
        check("t5_rx_n", 32'(rx_n), 32'd4);
        for (int i = 0; i < 4; i++) check("t5_rx", 32'(rx[i]), 32'(s5[i]));
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (done) begin
                dn++;
                check("t5_ok", 32'(done_ok), 32'd0);
            end
            tick();
        end
        check("t5_dn_cnt", 32'(dn), 32'd1);

        // reset in the middle of "a+b="
        chk_ready  = 1'b1;
        chk_result = 1'b1;
        req0_valid = 1'b1;
        req0_data  = CH_A;
        tick();
        tick();
        req0_data = CH_PL;
        tick();
        req0_data  = CH_B;
        req1_valid = 1'b1;
        req1_data  = CH_Z;
        settle();
        check("t6_cd_b", 32'(chk_data), 32'(CH_B));
        reset = 1'b0;
        settle();
        outs_zero("t6_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_dn", 32'(done), 32'd0);
            check("t6_ab", 32'(abort), 32'd0);
            check("t6_cv", 32'(chk_valid), 32'd0);
        end
        req0_data = CH_A;
        reset     = 1'b1;
        settle();
        check("t6_idle_r0", 32'(req0_ready), 32'd0);
        tick();
        check("t6_own", 32'(owner), 32'd0);
        check("t6_r0", 32'(req0_ready), 32'd1);
        check("t6_r1", 32'(req1_ready), 32'd0);
        check("t6_cd_a", 32'(chk_data), 32'(CH_A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eq_arbiter.md
EQ_ARBITER -- requirements
Module: eq_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum characters per expression, including '='; legal range 2..31.
REQ-002 Parameter TIMEOUT, default 8: consecutive owner-idle cycles before abort; legal range 1..31.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 req0_valid  input  1  requester 0 presents a character.
REQ-006 req0_data  input  8  requester 0 ASCII character.
REQ-007 req0_ready  output  1  requester 0 character accepted this cycle.
REQ-008 req1_valid / req1_data / req1_ready  input / input / output  1 / 8 / 1  requester 1; same meanings as requester 0.
REQ-009 chk_valid  output  1  character presented to the shared expression checker.
REQ-010 chk_data  output  8  character to the checker.
REQ-011 chk_ready  input  1  checker accepts a character.
REQ-012 chk_result  input  1  checker verdict, 1 = legal expression.
REQ-013 chk_clr  output  1  one-cycle pulse that clears the checker state.
REQ-014 owner  output  1  index of the current or last granted requester.
REQ-015 done  output  1  one-cycle pulse: expression completed with '='.
REQ-016 done_ok  output  1  verdict qualified by done.
REQ-017 abort  output  1  one-cycle pulse: expression dropped (length or timeout).

Function
REQ-018 States SHALL be IDLE, BUSY, DONE, ABORT and CLEAR.
REQ-019 Transfer definition: a character transfers in a cycle where chk_valid and chk_ready are both 1.
REQ-020 IDLE, one requester valid: that requester is granted.
REQ-021 IDLE, both requesters valid: grant goes to the requester that is not last, round-robin.
REQ-022 IDLE, grant action: owner is updated, counters are cleared, and the state goes to BUSY.
REQ-023 IDLE, no transfer: both readys are 0 and chk_valid is 0.
REQ-024 IDLE, arbitration latency: 1 cycle.
REQ-025 BUSY, forwarding: chk_valid = reqN_valid and chk_data = reqN_data for the owner; reqN_ready = chk_ready for the owner.
REQ-026 BUSY, non-owner: ready is held at 0, so the grant is locked for the whole expression.
REQ-027 BUSY, transfer: each transfer increments len_cnt (5-bit) and clears idle_cnt.
REQ-028 BUSY, idle cycles: each cycle with owner valid = 0 increments idle_cnt.
REQ-029 BUSY, backpressure: a cycle with owner valid = 1 and chk_ready = 0 leaves both counters unchanged.
REQ-030 BUSY, '=' exit: a transferred character equal to 0x3D moves the state to DONE.
REQ-031 BUSY, length exit: a non-'=' transfer that makes len_cnt equal MAX_LEN moves the state to ABORT.
REQ-032 BUSY, timeout exit: idle_cnt reaching TIMEOUT moves the state to ABORT.
REQ-033 BUSY, exit priority: '=' takes priority over the length limit when both apply on the same transfer.
REQ-034 DONE: lasts one cycle, with done = 1, done_ok = chk_result sampled this cycle, and no transfers; next state is CLEAR.
REQ-035 ABORT: lasts one cycle, with abort = 1, done = 0, done_ok = 0, and no transfers; next state is CLEAR.
REQ-036 CLEAR: lasts one cycle, with chk_clr = 1, last <= owner, and no transfers; next state is IDLE.
REQ-037 done, abort and chk_clr SHALL be Moore outputs decoded from the state register, and SHALL never be high together.
REQ-038 done_ok SHALL be 0 whenever done = 0.
REQ-039 Requester valid is not required to remain asserted while the requester is not granted; a non-owner is never acknowledged.

Reset
REQ-040 reset = 0 SHALL immediately force state = IDLE, owner = 0, last = 1, len_cnt = 0 and idle_cnt = 0.
REQ-041 reset = 0 SHALL force all outputs to 0: readys, chk_valid, chk_data = 0x00, chk_clr, done, done_ok and abort.
REQ-042 Reset asserted mid-expression SHALL discard the expression with no done or abort pulse; the first grant after release goes to requester 0 if both are valid.
REQ-043 The first clock edge after reset = 1 SHALL perform normal IDLE arbitration.

Verification
REQ-044 Requester 0 sends "a+1=" with chk_ready = 1 and chk_result = 1 -> 4 transfers on consecutive cycles after the 1-cycle grant; the next cycle has done = 1, done_ok = 1, owner = 0; the next has chk_clr = 1.
REQ-045 Both requesters valid continuously, each sending "x=" -> grants alternate 0,1,0,1; req1_ready = 0 throughout each requester-0 expression.
REQ-046 Requester 1 sends 16 characters from "a+a+a+a+a+a+a+a+" with no '=' (MAX_LEN = 16) -> abort = 1 one cycle after the 16th transfer, done stays 0, then chk_clr = 1.
REQ-047 Requester 0 sends "a+" then drops valid (TIMEOUT = 8) -> abort asserts after 8 idle cycles; a stall with chk_ready = 0 and valid = 1 does not advance the timeout.
REQ-048 chk_ready toggles 1,0,1,0 during "b*2=" -> each character is transferred exactly once, in order, and done fires once.
REQ-049 reset driven to 0 after 2 characters of "a+b=" -> all outputs 0 immediately; no done or abort pulse; with both requesters valid after release, requester 0 is granted first.
